legv8_instr_encoder: RTL and testbench
======================================

LEGV8_INSTR_ENCODER -- requirements
Module: legv8_instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, 2, output FIFO entries (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, 32, instruction address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports start, input, 1, pulse that loads base_addr, flushes the FIFO, clears err and enters RUN; and base_addr, input, ADDR_W, first instruction address.
REQ-006 SHALL have ports in_valid, input, 1, and in_ready, output, 1, forming the field-input handshake.
REQ-007 SHALL have ports in_op, input, 5, op enum; and in_rd, in_rn, in_rm, each input, 5, register numbers.
REQ-008 SHALL have port in_imm  input  32  two's-complement immediate/offset.
REQ-009 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_addr, output, ADDR_W; and out_instr, output, 32, the encoded word.
REQ-010 SHALL have ports instr_count, output, 16, words emitted; err, output, 1, sticky error; and err_code, output, 2, with 0=none, 1=illegal op, 2=range.

Function
REQ-011 SHALL encode the op enum 0..16 as ADD, SUB, AND, ORR, EOR, ADDI, SUBI, ANDI, ORRI, EORI, MOVZ, LDUR, STUR, CBZ, CBNZ, B, BL, using standard LEGv8 opcodes.
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000.
- ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000, EORI 1101001000.
- MOVZ 110100101, LDUR 11111000010, STUR 11111000000, CBZ 10110100, CBNZ 10110101, B 000101, BL 100101.
REQ-012 SHALL place fields by format.
- R: Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
- I: imm12[21:10].
- MOVZ: hw[22:21]=0, imm16[20:5].
- D: addr9[20:12], op2[11:10]=0, Rn[9:5], Rt=in_rd[4:0].
- CB: imm19[23:5], Rt=in_rd.
- B: imm26[25:0].
- Unused register inputs are ignored.
REQ-013 SHALL use these immediate ranges: I unsigned 0..4095; MOVZ 0..65535; D signed -256..255; CB signed -2^18..2^18-1; B signed -2^25..2^25-1.
REQ-014 SHALL reject in_op values 17..31 without pushing, set err=1 and set err_code=1.
REQ-015 SHALL implement FSM states IDLE and RUN.
- Reset enters IDLE.
- start moves IDLE->RUN and RUN->RUN (restart).
- in_ready=0 in IDLE.
REQ-016 SHALL drive in_ready = RUN and FIFO count<DEPTH and not start; it SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL, on acceptance (in_valid and in_ready), push {addr_ctr, word} and make it visible at the FIFO head no earlier than the next cycle (1-cycle latency when empty).
REQ-018 SHALL increment addr_ctr by 4 per push, wrapping modulo 2^ADDR_W.
REQ-019 SHALL present out_valid/out_addr/out_instr from the FIFO head, held stable while out_valid=1 and out_ready=0.
REQ-020 SHALL pop on out_valid and out_ready; simultaneous push and pop keeps the count and both operations complete.
REQ-021 SHALL increment instr_count on each pop, saturating at 0xFFFF.
REQ-022 SHALL make err sticky until start or reset, with err_code holding the most recent error.
REQ-023 SHALL let start override a same-cycle handshake: no push, FIFO emptied, instr_count=0, addr_ctr=base_addr.

Reset
REQ-024 SHALL, on reset=1 at a clock edge: state=IDLE, FIFO empty, out_valid=0, out_addr=0, out_instr=0, in_ready=0, addr_ctr=0, instr_count=0, err=0, err_code=0; mid-transfer words are discarded.

Configuration
REQ-025 SHALL, with ENCODER_RANGE_CHECK_EN defined, drop out-of-range immediates (no push, addr_ctr unchanged) and set err=1, err_code=2.
REQ-026 SHALL, without ENCODER_RANGE_CHECK_EN, encode the truncated low field bits with no error; err_code=2 is never produced.

Structure
REQ-027 SHALL keep the op enum, opcode constants, field widths/positions and err_code values in shared package legv8_pkg.
REQ-028 SHALL keep field packing and range checking in combinational sub-module legv8_instr_pack (op, regs, imm -> word, illegal, out_of_range); the FSM, FIFO and counters stay in the top.

Verification
REQ-029 SHALL cover: start base_addr=0x400, then ADD rd=1 rn=2 rm=3 -> out_instr=0x8B030041, out_addr=0x400, one cycle after accept.
REQ-030 SHALL cover: ADDI 9,9,#1, then LDUR rt=2 rn=10 imm=8 -> 0x91000529 @0x400, 0xF8408142 @0x404, instr_count=2.
REQ-031 SHALL cover: CBZ rt=5 imm=-2 -> 0xB4FFFFC5; B imm=-1 -> 0x17FFFFFF.
REQ-032 SHALL cover: ADDI 9,9,#4096 -> with macro no push, err=1, err_code=2; without macro -> 0x91000129.
REQ-033 SHALL cover: out_ready=0 and three valid inputs (DEPTH=2) -> in_ready falls after two pushes; release yields addrs base, base+4, then base+8.
REQ-034 SHALL cover: in_op=20 -> no output, err_code=1; then start with in_valid=1 in the same cycle -> no push, FIFO empty, err=0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoder definitions: op enum, opcodes, field layout,
// error codes and immediate range helpers.
package legv8_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_ORR  = 5'd3,
        OP_EOR  = 5'd4,
        OP_ADDI = 5'd5,
        OP_SUBI = 5'd6,
        OP_ANDI = 5'd7,
        OP_ORRI = 5'd8,
        OP_EORI = 5'd9,
        OP_MOVZ = 5'd10,
        OP_LDUR = 5'd11,
        OP_STUR = 5'd12,
        OP_CBZ  = 5'd13,
        OP_CBNZ = 5'd14,
        OP_B    = 5'd15,
        OP_BL   = 5'd16
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_RANGE   = 2'd2
    } err_e;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
    localparam logic [9:0]  OPC_EORI = 10'b1101001000;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [5:0]  OPC_BL   = 6'b100101;

    // Field widths and LSB positions inside the 32-bit word
    localparam int REG_W     = 5;
    localparam int SHAMT_W   = 6;
    localparam int IMM12_W   = 12;
    localparam int IMM16_W   = 16;
    localparam int ADDR9_W   = 9;
    localparam int IMM19_W   = 19;
    localparam int IMM26_W   = 26;
    localparam int RD_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int RM_LSB    = 16;
    localparam int IMM12_LSB = 10;
    localparam int IMM16_LSB = 5;
    localparam int ADDR9_LSB = 12;
    localparam int IMM19_LSB = 5;

    // Unsigned immediate fits in w bits
    function automatic logic fits_u(input logic [31:0] v, input int w);
        return v < (32'd1 << w);
    endfunction

    // Two's-complement immediate fits in w bits
    function automatic logic fits_s(input logic [31:0] v, input int w);
        logic signed [31:0] sv;
        logic signed [31:0] lim;
        sv  = $signed(v);
        lim = 32'sd1 <<< (w - 1);
        return (sv >= -lim) && (sv < lim);
    endfunction

endpackage

// File: rtl/legv8_instr_pack.sv
// Combinational LEGv8 field packer with illegal-op and range flags.
// Range flag is only raised when ENCODER_RANGE_CHECK_EN is defined.
module legv8_instr_pack
    import legv8_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        out_of_range
);

    logic in_range;

    // Select format by op and pack fields; truncate immediates to field width
    always_comb begin
        word     = '0;
        illegal  = 1'b0;
        in_range = 1'b1;
        case (op)
            OP_ADD:  word = {OPC_ADD, rm, 6'd0, rn, rd};
            OP_SUB:  word = {OPC_SUB, rm, 6'd0, rn, rd};
            OP_AND:  word = {OPC_AND, rm, 6'd0, rn, rd};
            OP_ORR:  word = {OPC_ORR, rm, 6'd0, rn, rd};
            OP_EOR:  word = {OPC_EOR, rm, 6'd0, rn, rd};
            OP_ADDI: begin
                word     = {OPC_ADDI, imm[IMM12_W-1:0], rn, rd};
                in_range = fits_u(imm, IMM12_W);
            end
            OP_SUBI: begin
                word     = {OPC_SUBI, imm[IMM12_W-1:0], rn, rd};
                in_range = fits_u(imm, IMM12_W);
            end
            OP_ANDI: begin
                word     = {OPC_ANDI, imm[IMM12_W-1:0], rn, rd};
                in_range = fits_u(imm, IMM12_W);
            end
            OP_ORRI: begin
                word     = {OPC_ORRI, imm[IMM12_W-1:0], rn, rd};
                in_range = fits_u(imm, IMM12_W);
            end
            OP_EORI: begin
                word     = {OPC_EORI, imm[IMM12_W-1:0], rn, rd};
                in_range = fits_u(imm, IMM12_W);
            end
            OP_MOVZ: begin
                word     = {OPC_MOVZ, 2'b00, imm[IMM16_W-1:0], rd};
                in_range = fits_u(imm, IMM16_W);
            end
            OP_LDUR: begin
                word     = {OPC_LDUR, imm[ADDR9_W-1:0], 2'b00, rn, rd};
                in_range = fits_s(imm, ADDR9_W);
            end
            OP_STUR: begin
                word     = {OPC_STUR, imm[ADDR9_W-1:0], 2'b00, rn, rd};
                in_range = fits_s(imm, ADDR9_W);
            end
            OP_CBZ: begin
                word     = {OPC_CBZ, imm[IMM19_W-1:0], rd};
                in_range = fits_s(imm, IMM19_W);
            end
            OP_CBNZ: begin
                word     = {OPC_CBNZ, imm[IMM19_W-1:0], rd};
                in_range = fits_s(imm, IMM19_W);
            end
            OP_B: begin
                word     = {OPC_B, imm[IMM26_W-1:0]};
                in_range = fits_s(imm, IMM26_W);
            end
            OP_BL: begin
                word     = {OPC_BL, imm[IMM26_W-1:0]};
                in_range = fits_s(imm, IMM26_W);
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    assign out_of_range = !illegal && !in_range;
`else
    logic unused_range;
    assign unused_range = in_range;
    assign out_of_range = 1'b0;
`endif

endmodule

// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: field handshake in, FIFO of {addr, word} out.
// Optional immediate range checking via ENCODER_RANGE_CHECK_EN.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic [15:0]       instr_count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] addr_ctr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [31:0]       mem_word [DEPTH];

    logic [31:0] word;
    logic        illegal;
    logic        oor;
    logic        accept;
    logic        push;
    logic        pop;

    legv8_instr_pack u_pack (
        .op           (in_op),
        .rd           (in_rd),
        .rn           (in_rn),
        .rm           (in_rm),
        .imm          (in_imm),
        .word         (word),
        .illegal      (illegal),
        .out_of_range (oor)
    );

    assign in_ready  = (state == RUN) && (count < FULL) && !start;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal && !oor;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_addr  = out_valid ? mem_addr[rd_ptr] : '0;
    assign out_instr = out_valid ? mem_word[rd_ptr] : '0;

    // FSM, FIFO pointers, address/instruction counters and error latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr_ctr    <= '0;
            instr_count <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else if (start) begin
            state       <= RUN;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr_ctr    <= base_addr;
            instr_count <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                addr_ctr <= addr_ctr + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (instr_count != 16'hFFFF)
                    instr_count <= instr_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && illegal) begin
                err      <= 1'b1;
                err_code <= ERR_ILLEGAL;
            end else if (accept && oor) begin
                err      <= 1'b1;
                err_code <= ERR_RANGE;
            end
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= addr_ctr;
            mem_word[wr_ptr] <= word;
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench for legv8_instr_encoder with a arithmetic reference model.
// Expectations follow ENCODER_RANGE_CHECK_EN when it is defined.
module tb_legv8_instr_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_instr;
    logic [15:0] instr_count;
    logic        err;
    logic [1:0]  err_code;

    legv8_instr_encoder #(.DEPTH(2), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rn       (in_rn),
        .in_rm       (in_rm),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_instr   (out_instr),
        .instr_count (instr_count),
        .err         (err),
        .err_code    (err_code)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_addr = 0;
    int          exp_count = 0;
    logic        exp_err = 0;
    int          exp_code = 0;
    bit          rnd_on = 0;
    bit          s3_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 0=R 1=I 2=MOVZ 3=D 4=CB 5=B
    function automatic int kind_of(input int op);
        if (op <= 4) return 0;
        if (op <= 9) return 1;
        if (op == 10) return 2;
        if (op <= 12) return 3;
        if (op <= 14) return 4;
        return 5;
    endfunction

    function automatic longint fld(input longint v, input int w);
        return v & ((64'sd1 <<< w) - 1);
    endfunction

    // st: 0 ok, 1 illegal op, 2 immediate out of range
    function automatic void ref_encode(input int op, input int rd, input int rn,
                                       input int rm, input logic [31:0] imm,
                                       output logic [31:0] w, output int st);
        longint v;
        longint r;
        longint opc;
        bit ok;
        v = longint'($signed(imm));
        w = 0;
        st = 0;
        if (op > 16) begin
            st = 1;
            return;
        end
        case (op)
            0: opc = 11'b10001011000;
            1: opc = 11'b11001011000;
            2: opc = 11'b10001010000;
            3: opc = 11'b10101010000;
            4: opc = 11'b11001010000;
            5: opc = 10'b1001000100;
            6: opc = 10'b1101000100;
            7: opc = 10'b1001001000;
            8: opc = 10'b1011001000;
            9: opc = 10'b1101001000;
            10: opc = 9'b110100101;
            11: opc = 11'b11111000010;
            12: opc = 11'b11111000000;
            13: opc = 8'b10110100;
            14: opc = 8'b10110101;
            15: opc = 6'b000101;
            default: opc = 6'b100101;
        endcase
        ok = 1;
        r = 0;
        case (kind_of(op))
            0: r = opc * (1 << 21) + rm * (1 << 16) + rn * 32 + rd;
            1: begin
                ok = (v >= 0) && (v <= 4095);
                r = opc * (1 << 22) + fld(v, 12) * (1 << 10) + rn * 32 + rd;
            end
            2: begin
                ok = (v >= 0) && (v <= 65535);
                r = opc * (1 << 23) + fld(v, 16) * 32 + rd;
            end
            3: begin
                ok = (v >= -256) && (v <= 255);
                r = opc * (1 << 21) + fld(v, 9) * (1 << 12) + rn * 32 + rd;
            end
            4: begin
                ok = (v >= -(64'sd1 <<< 18)) && (v < (64'sd1 <<< 18));
                r = opc * (1 << 24) + fld(v, 19) * 32 + rd;
            end
            default: begin
                ok = (v >= -(64'sd1 <<< 25)) && (v < (64'sd1 <<< 25));
                r = opc * (64'sd1 <<< 26) + fld(v, 26);
            end
        endcase
`ifdef ENCODER_RANGE_CHECK_EN
        if (!ok) begin
            st = 2;
            return;
        end
`else
        if (!ok) st = 0;
`endif
        w = r[31:0];
    endfunction

    // Present one field set and wait until the DUT accepts it
    task automatic send(input int op, input int rd, input int rn, input int rm,
                        input logic [31:0] imm, input bit use_k, input logic [31:0] k);
        logic [31:0] w;
        int st;
        int n;
        bit done;
        exp_t e;
        in_valid = 1'b1;
        in_op = op[4:0];
        in_rd = rd[4:0];
        in_rn = rn[4:0];
        in_rm = rm[4:0];
        in_imm = imm;
        n = 0;
        done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ref_encode(op, rd, rn, rm, imm, w, st);
                if (st == 0) begin
                    e.addr = exp_addr;
                    e.word = use_k ? k : w;
                    sbq.push_back(e);
                    exp_addr = exp_addr + 4;
                end else begin
                    exp_err = 1;
                    exp_code = st;
                end
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_start(input logic [31:0] base);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        sbq.delete();
        exp_addr = base;
        exp_count = 0;
        exp_err = 0;
        exp_code = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // Monitor: every handshaken output is checked against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !start && !reset) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", {32'd0, out_instr}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_addr", {32'd0, out_addr}, {32'd0, e.addr});
                    chk("out_instr", {32'd0, out_instr}, {32'd0, e.word});
                    exp_count++;
                end
            end
        end
    end

    // Random output back-pressure during the random phase
    initial begin
        wait (rnd_on);
        while (rnd_on) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        int op;
        int kd;
        logic [31:0] imm;

        reset = 1'b1;
        start = 1'b0;
        base_addr = 0;
        in_valid = 1'b0;
        in_op = 0;
        in_rd = 0;
        in_rn = 0;
        in_rm = 0;
        in_imm = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_addr", {32'd0, out_addr}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_count", {48'd0, instr_count}, 64'd0);
        chk("rst_err", {61'd0, err, err_code}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;

        // ADD with one-cycle visibility
        do_start(32'h400);
        out_ready = 1'b0;
        send(0, 1, 2, 3, 0, 1, 32'h8B030041);
        @(negedge clk);
        chk("add_latency_valid", {63'd0, out_valid}, 64'd1);
        chk("add_addr", {32'd0, out_addr}, 64'h400);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("add_count", {48'd0, instr_count}, 64'd1);

        // ADDI then LDUR
        do_start(32'h400);
        send(5, 9, 9, 0, 1, 1, 32'h91000529);
        send(11, 2, 10, 0, 8, 1, 32'hF8408142);
        drain();
        chk("two_count", {48'd0, instr_count}, 64'd2);

        // Negative branch offsets
        send(13, 5, 0, 0, -32'sd2, 1, 32'hB4FFFFC5);
        send(15, 0, 0, 0, -32'sd1, 1, 32'h17FFFFFF);
        drain();

        // ADDI immediate just past the 12-bit range
        do_start(32'h400);
`ifdef ENCODER_RANGE_CHECK_EN
        send(5, 9, 9, 0, 4096, 0, 0);
        idle_cycles(2);
        chk("range_no_push", {63'd0, out_valid}, 64'd0);
        chk("range_err", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd2});
`else
        send(5, 9, 9, 0, 4096, 1, 32'h91000129);
        drain();
        chk("trunc_no_err", {61'd0, err, err_code}, 64'd0);
`endif

        // Back-pressure fills the two-entry FIFO
        do_start(32'h800);
        out_ready = 1'b0;
        send(1, 4, 5, 6, 0, 0, 0);
        send(2, 7, 8, 9, 0, 0, 0);
        fork
            begin
                send(3, 10, 11, 12, 0, 0, 0);
                s3_done = 1;
            end
        join_none
        @(negedge clk);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) @(negedge clk);
        chk("hold_addr", {32'd0, out_addr}, 64'h800);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && !s3_done; i++) @(posedge clk);
        #1;
        drain();
        chk("bp_count", {48'd0, instr_count}, 64'd3);
        chk("bp_next_addr", {32'd0, exp_addr}, 64'h80C);

        // Illegal op, then start overriding a same-cycle handshake
        send(20, 1, 1, 1, 0, 0, 0);
        idle_cycles(2);
        chk("illegal_no_out", {63'd0, out_valid}, 64'd0);
        chk("illegal_err", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd1});
        start = 1'b1;
        base_addr = 32'h1000;
        in_valid = 1'b1;
        in_op = 0;
        @(negedge clk);
        chk("start_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        exp_addr = 32'h1000;
        exp_count = 0;
        exp_err = 0;
        exp_code = 0;
        @(negedge clk);
        chk("start_fifo_empty", {63'd0, out_valid}, 64'd0);
        chk("start_err_clr", {61'd0, err, err_code}, 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure
        do_start($urandom & 32'hFFFF_FFFC);
        rnd_on = 1;
        for (int i = 0; i < 300; i++) begin
            op = (($urandom % 16) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
            kd = kind_of(op);
            imm = $urandom;
            if (($urandom % 8) != 0) begin
                case (kd)
                    1: imm = $urandom_range(0, 4095);
                    2: imm = $urandom_range(0, 65535);
                    3: imm = $urandom_range(0, 511) - 256;
                    4: imm = $urandom_range(0, (1 << 19) - 1) - (1 << 18);
                    5: imm = $urandom_range(0, (1 << 26) - 1) - (1 << 25);
                    default: imm = $urandom;
                endcase
            end
            send(op, $urandom % 32, $urandom % 32, $urandom % 32, imm, 0, 0);
        end
        rnd_on = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        chk("rnd_count", {48'd0, instr_count}, 64'(exp_count));
        chk("rnd_err", {61'd0, err, err_code}, {61'd0, exp_err, 2'(exp_code)});

        // Reset discards words still in the FIFO
        do_start(32'h2000);
        out_ready = 1'b0;
        send(0, 1, 1, 1, 0, 0, 0);
        send(1, 2, 2, 2, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_count", {48'd0, instr_count}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
